// File: rtl/apb_mailbox_pkg.sv
// Shared constants for the APB mailbox: register offsets, STATUS bit positions
// and the encoding of the two-state transfer FSM.
package apb_mailbox_pkg;

  localparam logic [1:0] MB_REG_DATA   = 2'd0;
  localparam logic [1:0] MB_REG_STATUS = 2'd1;
  localparam logic [1:0] MB_REG_THRESH = 2'd2;

  localparam int MB_OVF   = 15;
  localparam int MB_UDF   = 14;
  localparam int MB_FULL  = 13;
  localparam int MB_EMPTY = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

endpackage

// File: rtl/apb_mailbox_fifo_sync_fifo.sv
// Single-clock FIFO with a combinational head view; a push while full or a pop
// while empty is silently ignored.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointers are exactly log2(DEPTH) bits, so the increment wraps by itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_mailbox_fifo.sv
// APB mailbox: one-wait-state slave fronting a message FIFO, with sticky
// overflow/underflow flags, an occupancy threshold and a level interrupt.
module apb_mailbox_fifo
  import apb_mailbox_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  output logic                  irq
);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  r_irq;
  logic [CNT_W-1:0]      r_thresh;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic                  w_access;
  logic                  w_wr;
  logic                  w_rd;
  logic [1:0]            w_addr;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_status_wr;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  // Upper address bits were already decoded by the interconnect.
  assign w_unused = &{1'b0, S_PADDR[BUS_WIDTH-1:2]};

  assign w_addr      = S_PADDR[1:0];
  assign w_access    = S_PSELx & S_PENABLE & (r_state == ST_IDLE);
  assign w_wr        = w_access & S_PWRITE;
  assign w_rd        = w_access & ~S_PWRITE;
  assign w_push      = w_wr & (w_addr == MB_REG_DATA);
  assign w_pop       = w_rd & (w_addr == MB_REG_DATA);
  assign w_status_wr = w_wr & (w_addr == MB_REG_STATUS);

  assign S_PREADY = (r_state == ST_ACK);
  assign S_PRDATA = r_prdata;
  assign irq      = r_irq;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (S_PWDATA),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_access) w_state_next = ST_ACK;
      ST_ACK:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Read mux sees pre-commit state, so STATUS reports flags before this access.
  always_comb begin
    w_status                = '0;
    w_status[MB_OVF]        = r_ovf;
    w_status[MB_UDF]        = r_udf;
    w_status[MB_FULL]       = w_full;
    w_status[MB_EMPTY]      = w_empty;
    w_status[CNT_W-1:0]     = w_count;
    w_rdata                 = '0;
    case (w_addr)
      MB_REG_DATA:   if (!w_empty) w_rdata = w_head;
      MB_REG_STATUS: w_rdata = w_status;
      MB_REG_THRESH: w_rdata[CNT_W-1:0] = r_thresh;
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_irq    <= 1'b0;
      r_thresh <= '0;
      r_prdata <= '0;
    end else begin
      r_irq <= (r_thresh != '0) && (w_count >= r_thresh);

      if (w_access)               r_prdata <= w_rdata;
      else if (r_state == ST_ACK) r_prdata <= '0;

      if (w_push && w_full)                         r_ovf <= 1'b1;
      else if (w_status_wr && S_PWDATA[MB_OVF])     r_ovf <= 1'b0;

      if (w_pop && w_empty)                         r_udf <= 1'b1;
      else if (w_status_wr && S_PWDATA[MB_UDF])     r_udf <= 1'b0;

      if (w_wr && (w_addr == MB_REG_THRESH)) r_thresh <= S_PWDATA[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_apb_mailbox_fifo.sv
// Directed bench for the APB mailbox: ordering, overflow, underflow/W1C,
// threshold interrupt and reset during a committing transfer.
module tb_apb_mailbox_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] S_PADDR;
  logic        S_PWRITE;
  logic        S_PSELx;
  logic        S_PENABLE;
  logic [15:0] S_PWDATA;
  logic [15:0] S_PRDATA;
  logic        S_PREADY;
  logic        irq;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] rd;
  logic        irq_at_ack;
  logic        irq_after;
  logic        seen_rdy;

  always #5 clk = ~clk;

  apb_mailbox_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (S_PADDR),
    .S_PWRITE  (S_PWRITE),
    .S_PSELx   (S_PSELx),
    .S_PENABLE (S_PENABLE),
    .S_PWDATA  (S_PWDATA),
    .S_PRDATA  (S_PRDATA),
    .S_PREADY  (S_PREADY),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full APB transfer; checks PREADY arrives on the 2nd access cycle and drops after.
  task automatic apb_xfer(input logic wr, input logic [1:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata);
    int cyc;
    logic seen;
    @(posedge clk); #1;
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = wr;
    S_PADDR = {14'b0, addr}; S_PWDATA = wdata;
    @(posedge clk); #1;
    S_PENABLE = 1'b1;
    cyc = 0; seen = 1'b0; rdata = '0; irq_at_ack = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (S_PREADY) begin
        seen = 1'b1;
        rdata = S_PRDATA;
        irq_at_ack = irq;
      end
    end
    chk("ready_cycle", seen ? cyc : 0, 2);
    @(posedge clk); #1;
    S_PSELx = 1'b0; S_PENABLE = 1'b0;
    @(negedge clk);
    irq_after = irq;
    chk("ready_drop", {15'b0, S_PREADY, S_PRDATA}, 0);
    $display("xfer %s addr=%0d wdata=%h rdata=%h irq=%b", wr ? "WR" : "RD", addr, wdata, rdata, irq_after);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    logic [15:0] dummy;
    apb_xfer(1'b1, addr, data, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    apb_xfer(1'b0, addr, 16'h0000, rd);
    chk(tag, rd, exp);
  endtask

  initial begin
    reset = 1'b0; S_PADDR = '0; S_PWRITE = 1'b0; S_PSELx = 1'b0;
    S_PENABLE = 1'b0; S_PWDATA = '0;

    // Reset sequencing
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {14'b0, irq, S_PREADY, S_PRDATA}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    rd_chk("rst_status", 2'd1, 16'h1000);
    chk("rst_irq", irq, 0);

    // FIFO ordering
    wr(2'd0, 16'h0011);
    wr(2'd0, 16'h0022);
    wr(2'd0, 16'h0033);
    rd_chk("ord_status3", 2'd1, 16'h0003);
    rd_chk("ord_d0", 2'd0, 16'h0011);
    rd_chk("ord_d1", 2'd0, 16'h0022);
    rd_chk("ord_d2", 2'd0, 16'h0033);
    rd_chk("ord_status0", 2'd1, 16'h1000);

    // Overflow: 9 writes into 8 entries
    for (int i = 0; i < 9; i++) wr(2'd0, 16'(16'h0100 + i));
    rd_chk("ovf_status", 2'd1, 16'hA008);
    for (int i = 0; i < 8; i++) rd_chk("ovf_data", 2'd0, 16'(16'h0100 + i));
    rd_chk("ovf_drained", 2'd1, 16'h9000);

    // W1C: only bit 15 clears OVF
    wr(2'd1, 16'h4000);
    rd_chk("w1c_udf_bit_keeps_ovf", 2'd1, 16'h9000);
    wr(2'd1, 16'h7FFF);
    rd_chk("w1c_other_bits", 2'd1, 16'h9000);
    wr(2'd1, 16'h8000);
    rd_chk("w1c_ovf_clear", 2'd1, 16'h1000);

    // Underflow
    rd_chk("udf_data", 2'd0, 16'h0000);
    rd_chk("udf_status", 2'd1, 16'h5000);
    wr(2'd1, 16'h4000);
    rd_chk("udf_clear", 2'd1, 16'h1000);

    // Threshold interrupt
    wr(2'd2, 16'hFFF3);
    rd_chk("thresh_mask", 2'd2, 16'h0003);
    wr(2'd0, 16'h00A1);
    chk("irq_push1", irq_after, 0);
    wr(2'd0, 16'h00A2);
    chk("irq_push2", irq_after, 0);
    wr(2'd0, 16'h00A3);
    chk("irq_push3_ack", irq_at_ack, 0);
    chk("irq_push3_after", irq_after, 1);
    rd_chk("irq_pop_data", 2'd0, 16'h00A1);
    chk("irq_pop_ack", irq_at_ack, 1);
    chk("irq_pop_after", irq_after, 0);
    wr(2'd2, 16'h0002);
    chk("irq_thresh2", irq_after, 1);
    wr(2'd2, 16'h0000);
    chk("irq_thresh0", irq_after, 0);
    for (int i = 0; i < 6; i++) wr(2'd0, 16'(16'h00B0 + i));
    chk("irq_thresh0_full", irq_after, 0);
    rd_chk("full_status", 2'd1, 16'h2008);

    // Reserved offset
    rd_chk("rsvd_read", 2'd3, 16'h0000);
    wr(2'd3, 16'hFFFF);
    rd_chk("rsvd_status", 2'd1, 16'h2008);
    rd_chk("thresh_zero", 2'd2, 16'h0000);

    // Reset lands on the commit edge of a DATA write
    @(posedge clk); #1;
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b1;
    S_PADDR = 16'h0000; S_PWDATA = 16'h0077;
    @(posedge clk); #1;
    S_PENABLE = 1'b1; reset = 1'b0;
    seen_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (S_PREADY) seen_rdy = 1'b1;
    end
    chk("rstmid_no_pready", seen_rdy, 0);
    @(posedge clk); #1;
    S_PSELx = 1'b0; S_PENABLE = 1'b0; reset = 1'b1;
    rd_chk("rstmid_status", 2'd1, 16'h1000);
    wr(2'd0, 16'h0055);
    rd_chk("rstmid_next_data", 2'd0, 16'h0055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_mailbox_fifo.md
Name: apb_mailbox_fifo

Overview:
- APB slave on one of the `M_PSELx` ports of `apb_intercon_s`; gives the cluster cores a hardware message queue for inter-core communication.
- A core writes words into a FIFO and another core pops them.
- Status, threshold and interrupt logic allow polling or interrupt-driven consumers.
- The block inserts exactly one wait state per transfer, so the interconnect's `PREADY` handling is exercised.

Parameters:
- `BUS_WIDTH`, 16: width of `PADDR`.
- `DATA_WIDTH`, 16: width of `PWDATA`/`PRDATA` and of each FIFO entry; must be at least 16.
- `DEPTH`, 8: FIFO entries; power of two, from 2 to 256.
- `CNT_W`, clog2(DEPTH)+1: occupancy counter width (derived).

Ports:
- `clk`  in  1  single clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `S_PADDR`  in  BUS_WIDTH  APB address; only bits [1:0] are decoded here, upper bits were decoded by the interconnect.
- `S_PWRITE`  in  1  1 = write, 0 = read.
- `S_PSELx`  in  1  slave select from the interconnect.
- `S_PENABLE`  in  1  APB access phase.
- `S_PWDATA`  in  DATA_WIDTH  write data.
- `S_PRDATA`  out  DATA_WIDTH  read data, valid while `S_PREADY`=1.
- `S_PREADY`  out  1  transfer completion.
- `irq`  out  1  level interrupt: `count` >= `THRESH` and `THRESH` != 0.

Behaviour:
- **Reset** (`reset`=0 at a rising edge):
  - FIFO emptied; pointers and `count` = 0.
  - `THRESH` = 0; `OVF` = 0; `UDF` = 0.
  - `S_PREADY` = 0; `S_PRDATA` = 0; `irq` = 0.
  - Reset overrides any in-flight transfer; that transfer is abandoned and no `PREADY` is issued.
- **FSM states:**
  - IDLE: `S_PREADY`=0. On `S_PSELx` & `S_PENABLE`, the register action commits at this edge, `S_PRDATA` is registered, and the FSM goes to ACK.
  - ACK: `S_PREADY`=1 for exactly one cycle; `S_PRDATA` is held. Then the FSM returns to IDLE unconditionally.
  - The setup phase (`S_PSELx` & !`S_PENABLE`) takes no action.
- **Latency:** first access cycle has `PREADY`=0, second access cycle has `PREADY`=1 (one wait state). Back-to-back transfers need the master's new setup phase, so no transfer can commit twice.
- **`S_PRDATA` outside ACK:** 0.
- **Register map** (`S_PADDR[1:0]`):
  - 0 DATA:
    - Write pushes `S_PWDATA`; if full, the data is dropped and `OVF` is set.
    - Read pops the head; if empty, it returns 0, sets `UDF`, and the pointers are unchanged.
  - 1 STATUS read: [15] `OVF`, [14] `UDF`, [13] full, [12] empty, [CNT_W-1:0] `count`, other bits 0.
  - 1 STATUS write: W1C. `S_PWDATA`[15]=1 clears `OVF`, [14]=1 clears `UDF`; other bits ignored.
  - 2 THRESH: read/write; low CNT_W bits stored, upper bits read as 0.
  - 3 reserved: reads 0, writes ignored, still completes with `PREADY`.
- **FIFO:**
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - `count` ranges 0..DEPTH.
  - full = (`count`==DEPTH); empty = (`count`==0).
- **Simultaneous events:** none are possible, because there is a single APB port and one action per transfer.
- **Flag reporting:** a read of STATUS reports flags as they were before that cycle.
- **irq:** registered, updated the cycle after `count`/`THRESH` change. It is 0 whenever `THRESH`=0.

Decomposition:
- Package `apb_mailbox_pkg`:
  - register offset constants `MB_REG_DATA`=0, `MB_REG_STATUS`=1, `MB_REG_THRESH`=2;
  - STATUS bit index constants `MB_OVF`=15, `MB_UDF`=14, `MB_FULL`=13, `MB_EMPTY`=12;
  - FSM state encodings IDLE and ACK.
- Sub-module `sync_fifo` (params `DATA_WIDTH`, `DEPTH`):
  - ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`;
  - `dout` shows the head combinationally;
  - push when full and pop when empty are ignored internally.
- The top level holds the APB FSM, flags, `THRESH` and `irq`.

Test Plan:
- Reset sequencing: drive `reset`=0 for 5 cycles, then 1, then read STATUS → `PREADY` high exactly 1 cycle, 2nd access cycle; `PRDATA`=0x1000 (empty); `irq`=0.
- FIFO ordering: write DATA 0x0011, 0x0022, 0x0033, then read STATUS → 0x0003; then 3 DATA reads → 0x0011, 0x0022, 0x0033 in order; STATUS → 0x1000.
- Overflow with DEPTH=8: write 9 words 0x0100..0x0108 → STATUS=0xA008 (`OVF`, full, count 8). Read 8 → 0x0100..0x0107; 0x0108 is lost.
- Underflow and W1C: read DATA on empty → 0x0000 and STATUS=0x5000. Write STATUS 0x4000 → STATUS=0x1000. A prior `OVF` is cleared only by writing 0x8000.
- Threshold interrupt:
  - write THRESH=3, then push 3 words → `irq` rises the cycle after the 3rd commit;
  - pop 1 → `irq` falls;
  - write THRESH=0 → `irq` stays 0 regardless of count.
- Reset mid-transfer: assert `reset`=0 in the IDLE→ACK commit cycle of a DATA write → no `PREADY`, `count`=0 after release; the next transfer completes normally.
